// File: rtl/if_id_skid.sv
`default_nettype none
// ============================================================================
// Module   : if_id_skid
// Purpose  : IF/ID pipeline stage with a 2-entry skid buffer, registered
//            up_ready and synchronous flush. Optional statistics counters are
//            enabled by defining IF_ID_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_skid #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [ADDR_W-1:0] up_pc,
    input  logic [INST_W-1:0] up_inst,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [ADDR_W-1:0] dn_pc,
`ifdef IF_ID_STAT_EN
    output logic [INST_W-1:0] dn_inst,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`else
    output logic [INST_W-1:0] dn_inst
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b10
    } state_t;

    state_t              r_state;
    logic                r_dn_valid;
    logic                r_up_ready;
    logic [ADDR_W-1:0]   r_main_pc;
    logic [INST_W-1:0]   r_main_inst;
    logic [ADDR_W-1:0]   r_skid_pc;
    logic [INST_W-1:0]   r_skid_inst;

    logic                w_up_xfer;
    logic                w_dn_xfer;
    logic                w_illegal;

    assign w_up_xfer = up_valid & r_up_ready;
    assign w_dn_xfer = r_dn_valid & dn_ready;
    assign w_illegal = (r_state != S_EMPTY) && (r_state != S_ONE) && (r_state != S_FULL);

    // The unused 2'b11 encoding is folded into the clear path so it lands in EMPTY.
    always_ff @(posedge clk) begin
        if (rst || flush || w_illegal) begin
            r_state     <= S_EMPTY;
            r_dn_valid  <= 1'b0;
            r_up_ready  <= 1'b1;
            r_main_pc   <= '0;
            r_main_inst <= NOP_INST;
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_up_xfer) begin
                        r_main_pc   <= up_pc;
                        r_main_inst <= up_inst;
                        r_dn_valid  <= 1'b1;
                        r_state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_up_xfer && w_dn_xfer) begin
                        r_main_pc   <= up_pc;
                        r_main_inst <= up_inst;
                    end else if (w_up_xfer) begin
                        // Decode stalled: park the new entry and drop ready next cycle.
                        r_skid_pc   <= up_pc;
                        r_skid_inst <= up_inst;
                        r_up_ready  <= 1'b0;
                        r_state     <= S_FULL;
                    end else if (w_dn_xfer) begin
                        r_main_pc   <= '0;
                        r_main_inst <= NOP_INST;
                        r_dn_valid  <= 1'b0;
                        r_state     <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_dn_xfer) begin
                        r_main_pc   <= r_skid_pc;
                        r_main_inst <= r_skid_inst;
                        r_skid_pc   <= '0;
                        r_skid_inst <= '0;
                        r_up_ready  <= 1'b1;
                        r_state     <= S_ONE;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

    assign up_ready = r_up_ready;
    assign dn_valid = r_dn_valid;
    assign dn_pc    = r_main_pc;
    assign dn_inst  = r_main_inst;

`ifdef IF_ID_STAT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Counters survive flush; only reset clears them. Both saturate at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_dn_valid && !dn_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (!r_dn_valid && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_skid
// Purpose  : Directed self-checking bench for if_id_skid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_skid;

    localparam int          ADDR_W = 32;
    localparam int          INST_W = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              up_valid;
    logic              up_ready;
    logic [ADDR_W-1:0] up_pc;
    logic [INST_W-1:0] up_inst;
    logic              dn_valid;
    logic              dn_ready;
    logic [ADDR_W-1:0] dn_pc;
    logic [INST_W-1:0] dn_inst;
`ifdef IF_ID_STAT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
`endif

    int r_total = 0;
    int r_bad   = 0;

    if_id_skid #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .NOP_INST (NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_pc      (up_pc),
        .up_inst    (up_inst),
        .dn_valid   (dn_valid),
        .dn_ready   (dn_ready),
        .dn_pc      (dn_pc),
`ifdef IF_ID_STAT_EN
        .dn_inst    (dn_inst),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`else
        .dn_inst    (dn_inst)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hC0DE_0000 | pc;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        r_total++;
        if (got !== exp) begin
            r_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] pc);
        up_valid = v;
        up_pc    = pc;
        up_inst  = inst_of(pc);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_dv"}, 64'(dn_valid), 64'd0);
        chk({tag, "_pc"}, 64'(dn_pc), 64'd0);
        chk({tag, "_inst"}, 64'(dn_inst), 64'(NOP));
        chk({tag, "_ur"}, 64'(up_ready), 64'd1);
    endtask

    task automatic chk_main(input string tag, input logic [31:0] pc, input logic ur);
        chk({tag, "_dv"}, 64'(dn_valid), 64'd1);
        chk({tag, "_pc"}, 64'(dn_pc), 64'(pc));
        chk({tag, "_inst"}, 64'(dn_inst), 64'(inst_of(pc)));
        chk({tag, "_ur"}, 64'(up_ready), 64'(ur));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; dn_ready = 1'b0;
        present(1'b1, 32'h4);
        tick(); tick();
        chk_empty("reset");

        // Streaming at full throughput
        rst = 1'b0; dn_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            present(1'b1, 32'(4 * i));
            tick();
            chk_main($sformatf("stream%0d", i), 32'(4 * i), 1'b1);
        end
        present(1'b0, 32'h0);
        tick();
        chk_empty("drain");

        // Stall into the skid register and release
        present(1'b1, 32'h10);
        tick();
        chk_main("skid_main", 32'h10, 1'b1);
        dn_ready = 1'b0;
        present(1'b1, 32'h14);
        tick();
        chk_main("skid_full", 32'h10, 1'b0);
        present(1'b0, 32'h0);
        tick();
        chk_main("skid_hold", 32'h10, 1'b0);
        dn_ready = 1'b1;
        tick();
        chk_main("skid_rel", 32'h14, 1'b1);
        tick();
        chk_empty("skid_drain");

        // Flush while FULL, with an upstream transfer in the flush cycle
        dn_ready = 1'b0;
        present(1'b1, 32'h20);
        tick();
        present(1'b1, 32'h24);
        tick();
        chk_main("fl_full", 32'h20, 1'b0);
        flush = 1'b1;
        present(1'b1, 32'h28);
        tick();
        chk_empty("flush");
        flush = 1'b0; dn_ready = 1'b1;
        present(1'b0, 32'h0);
        tick();
        chk_empty("flush_after1");
        tick();
        chk_empty("flush_after2");

        // Reset in the middle of a stall
        dn_ready = 1'b0;
        present(1'b1, 32'h40);
        tick();
        present(1'b1, 32'h44);
        tick();
        chk_main("rs_full", 32'h40, 1'b0);
        rst = 1'b1;
        present(1'b0, 32'h0);
        tick();
        chk_empty("rst_mid");
        rst = 1'b0;
        present(1'b1, 32'h30);
        tick();
        chk_main("post_rst", 32'h30, 1'b1);
        present(1'b0, 32'h0);
        dn_ready = 1'b1;
        tick();
        chk_empty("post_rst_drain");

`ifdef IF_ID_STAT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("st_rst_stall", 64'(stall_cnt), 64'd0);
        chk("st_rst_bub", 64'(bubble_cnt), 64'd0);
        dn_ready = 1'b0;
        present(1'b1, 32'h50);
        tick();
        present(1'b0, 32'h0);
        repeat (5) tick();
        chk("st_stall5", 64'(stall_cnt), 64'd5);
        chk("st_bub1", 64'(bubble_cnt), 64'd1);
        dn_ready = 1'b1;
        tick();
        repeat (3) tick();
        chk("st_bub4", 64'(bubble_cnt), 64'd4);
        chk("st_stall_kept", 64'(stall_cnt), 64'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("st_fl_stall", 64'(stall_cnt), 64'd5);
        chk("st_fl_bub", 64'(bubble_cnt), 64'd5);
        dn_ready = 1'b0;
        present(1'b1, 32'h60);
        tick();
        present(1'b0, 32'h0);
        repeat (20) tick();
        chk("st_sat", 64'(stall_cnt), 64'hF);
        chk("st_sat_bub", 64'(bubble_cnt), 64'd6);
`endif

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule
`default_nettype wire
